// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the multi-cycle shift sequencer.
//   state_t       FSM states of the sequencer (IDLE, SHIFT, DONE)
//   DIR_LEFT      direction code for logical left (zero fill)
//   DIR_RIGHT     direction code for arithmetic right (sign fill)
//   SHIFT_STAGES  number of power-of-two shift stages
//   STAGE_AMT     shift amounts in issue order (16 first, 1 last)
//   LAST_STAGE    index of the first stage processed after an accept
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SHIFT_STAGES = 5;

    // Issue order: entry 0 is processed first (stage index 4, amount 16).
    localparam int STAGE_AMT [SHIFT_STAGES] = '{16, 8, 4, 2, 1};

    localparam logic [2:0] LAST_STAGE = 3'(SHIFT_STAGES - 1);

endpackage

// File: rtl/shift_stage_select.sv
// shift_stage_select: one combinational step of the shift sequencer.
// A bank of fixed-amount shifters (2^k for k = 0..4) in both directions
// feeds a 5:1 select on the stage index; when the amount bit for the stage
// is clear the accumulator passes through untouched.
// Ports:
//   acc    in  WIDTH  current accumulator value
//   stage  in  3      stage index 0..4 (shift by 2^stage)
//   en     in  1      amount bit for this stage; 0 = pass through
//   dir    in  1      0 = logical left, 1 = arithmetic right
//   y      out WIDTH  accumulator after this stage
module shift_stage_select
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       stage,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] acc_s;
    logic        [WIDTH-1:0] cand [SHIFT_STAGES];

    assign acc_s = acc;

    for (genvar g = 0; g < SHIFT_STAGES; g++) begin : g_fixed
        // cand[g] shifts by 2^g; STAGE_AMT is stored in issue order.
        localparam int AMT = STAGE_AMT[SHIFT_STAGES - 1 - g];

        logic        [WIDTH-1:0] sll;
        logic signed [WIDTH-1:0] sra;

        // Kept as separate signals so the arithmetic shift is evaluated in a
        // signed context and really replicates bit 31.
        assign sll = acc << AMT;
        assign sra = acc_s >>> AMT;

        assign cand[g] = (dir == DIR_RIGHT) ? sra : sll;
    end

    always_comb begin
        y = acc;
        if (en) begin
            case (stage)
                3'd0:    y = cand[0];
                3'd1:    y = cand[1];
                3'd2:    y = cand[2];
                3'd3:    y = cand[3];
                3'd4:    y = cand[4];
                default: y = acc;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shifter feeding the ALU result mux.
// A request is taken over a valid/ready handshake, then the 16/8/4/2/1
// stages are applied one per clock (always five clocks, whatever the
// amount) and the registered result is offered on a second handshake.
// Ports:
//   clock      in  1      rising-edge clock
//   reset_n    in  1      asynchronous active-low reset
//   in_valid   in  1      request present
//   in_ready   out 1      unit can accept a request (IDLE only)
//   A          in  WIDTH  operand
//   shamt      in  5      shift amount 0..31
//   d          in  1      0 = logical left, 1 = arithmetic right
//   out_valid  out 1      result available (DONE)
//   out_ready  in  1      consumer accepts the result
//   result     out WIDTH  shifted operand, held until the next completion
//   busy       out 1      high in SHIFT or DONE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [4:0]       shamt,
    input  logic             d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [2:0] FIRST_STAGE = 3'(NUM_STAGES - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [4:0]       amt;
    logic             dir;
    logic [2:0]       stage;
    logic             stage_en;

    assign stage_en = amt[stage];

    shift_stage_select #(
        .WIDTH (WIDTH)
    ) u_stage_select (
        .acc   (acc),
        .stage (stage),
        .en    (stage_en),
        .dir   (dir),
        .y     (acc_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            acc       <= '0;
            amt       <= '0;
            dir       <= DIR_LEFT;
            stage     <= FIRST_STAGE;
        end else begin
            case (state)
                // Accept: operand, amount and direction are latched here and
                // never sampled again, so the inputs may churn afterwards.
                IDLE: begin
                    if (in_valid) begin
                        acc      <= A;
                        amt      <= shamt;
                        dir      <= d;
                        stage    <= FIRST_STAGE;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end

                // One power-of-two stage per clock, 16 down to 1.
                SHIFT: begin
                    acc <= acc_next;
                    if (stage == 3'd0) begin
                        result    <= acc_next;
                        out_valid <= 1'b1;
                        stage     <= FIRST_STAGE;
                        state     <= DONE;
                    end else begin
                        stage <= stage - 3'd1;
                    end
                end

                // Hold the result until the consumer takes it; no accept on
                // the same edge as the output handshake.
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(
        .WIDTH      (32),
        .NUM_STAGES (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .shamt     (shamt),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic        dr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and let it be accepted on the next edge.
    task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic dr);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
        A        = a;
        shamt    = s;
        d        = dr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; in_ready must stay low.
    task automatic wait_done(input string name, input bit churn, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
            chk({name, "_busy_shift"}, {31'd0, busy}, 32'd1);
            if (churn) begin
                A     = $urandom;
                shamt = 5'($urandom_range(0, 31));
                d     = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd5);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_txn(input string name, input logic [31:0] a, input logic [4:0] s,
                           input logic dr, input logic [31:0] exp, input bit churn);
        int lat;
        issue(a, s, dr);
        wait_done(name, churn, lat);
        chk({name, "_result"}, result, exp);
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
        drain(name);
        chk({name, "_result_hold"}, result, exp);
    endtask

    initial begin
        int lat;

        vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000};
        vecs[1] = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F};
        vecs[2] = '{32'hFFFF_FFFF, 5'd17, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{32'h1234_5678, 5'd4,  1'b0, 32'h2345_6780};
        vecs[6] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{32'h0000_0001, 5'd21, 1'b0, 32'h0020_0000};
        vecs[8] = '{32'hF000_0000, 5'd1,  1'b0, 32'hE000_0000};
        vecs[9] = '{32'h8765_4321, 5'd11, 1'b1, 32'hFFF0_ECA8};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        shamt     = '0;
        d         = 1'b0;

        #12;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_result",    result,             32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Table of single transactions.
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].dr, vecs[i].exp, 1'b0);
        end

        // Backpressure with a ghost request while DONE.
        issue(32'h0000_0F0F, 5'd4, 1'b0);
        wait_done("bp", 1'b0, lat);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                A        = 32'h1234_5678;
                shamt    = 5'd1;
                d        = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_result_stable", result, 32'h0000_F0F0);
            chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain("bp");
        chk("bp_result_once", result, 32'h0000_F0F0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("bp_no_ghost_valid", {31'd0, out_valid}, 32'd0);
            chk("bp_no_ghost_busy", {31'd0, busy}, 32'd0);
        end

        // Asynchronous reset while stage 2 is pending.
        issue(32'h0000_0005, 5'd3, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_no_output", {31'd0, out_valid}, 32'd0);
        run_txn("after_rst", 32'h0000_0003, 5'd2, 1'b0, 32'h0000_000C, 1'b0);

        // Input churn after acceptance.
        run_txn("churn", 32'h0000_FF00, 5'd8, 1'b1, 32'h0000_00FF, 1'b1);

        // Back-to-back issue right after a drain.
        run_txn("b2b_a", 32'h0000_00FF, 5'd24, 1'b0, 32'hFF00_0000, 1'b0);
        run_txn("b2b_b", 32'hFF00_0000, 5'd24, 1'b1, 32'hFFFF_FFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
